mux_scan_sampler: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 13 +
 rtl/next_ch_find.sv | 25 ++
 rtl/mux_scan_sampler.sv | 104 ++++++++++
 tb/tb_mux_scan_sampler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sampler.
package mux_scan_pkg;

  localparam int unsigned NCH   = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    DWELL_ST,
    DONE_ST
  } state_t;

endpackage

// File: rtl/next_ch_find.sv
// Combinational priority finder: lowest set mask bit strictly above idx,
// or the lowest set bit overall when first is high.
module next_ch_find
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] idx,
  input  logic             first,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  // Walk from the top down so the lowest qualifying channel is the last written.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int unsigned i = NCH; i > 0; i--) begin
      if (mask[i-1] && (first || (SEL_W'(i-1) > idx))) begin
        nxt   = SEL_W'(i-1);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sampler.sv
// Scans enabled channels of an external 4:1 mux in ascending order, holding
// each select for DWELL cycles, and captures the mux output into sample.
module mux_scan_sampler
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [NCH-1:0] ch_mask,
  input  logic           mux_out,
  output logic           s0,
  output logic           s1,
  output logic           busy,
  output logic           done,
  output logic [NCH-1:0] sample
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] ch;
  logic [SEL_W-1:0] nxt;
  logic [NCH-1:0]   mask_q;
  logic [NCH-1:0]   find_mask;
  logic             found;
  logic             in_idle;
  logic             dwell_end;

  assign in_idle   = (state == IDLE);
  assign dwell_end = (state == DWELL_ST) && (cnt == CNT_LAST);

  // In IDLE the finder looks at the live mask from index "-1" to pick the
  // first channel; during a scan it steps through the latched mask.
  assign find_mask = in_idle ? ch_mask : mask_q;

  next_ch_find u_find (
    .mask  (find_mask),
    .idx   (ch),
    .first (in_idle),
    .nxt   (nxt),
    .found (found)
  );

  // Next-state logic; abort returns to IDLE from any state.
  always_comb begin
    state_d = state;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) state_d = found ? DWELL_ST : DONE_ST;
        DWELL_ST: if (dwell_end && !found) state_d = DONE_ST;
        DONE_ST:  state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Datapath: mask latch, select, dwell counter and capture; abort freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      ch     <= '0;
      mask_q <= '0;
      sample <= '0;
    end else if (!abort) begin
      if (in_idle && start) begin
        sample <= '0;
        if (found) begin
          mask_q <= ch_mask;
          ch     <= nxt;
          cnt    <= '0;
        end
      end else if (state == DWELL_ST) begin
        if (dwell_end) begin
          sample[ch] <= mux_out;
          cnt        <= '0;
          if (found) ch <= nxt;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Select pair carries the channel index MSB-first; status decodes the state.
  assign s0   = ch[1];
  assign s1   = ch[0];
  assign busy = (state == DWELL_ST);
  assign done = (state == DONE_ST);

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Self-checking bench for mux_scan_sampler: queue-based scan model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_mux_scan_sampler;

  localparam int unsigned DW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] ch_mask = 4'b0000;
  logic [3:0] ins = 4'b0000;
  logic       mux_out;
  logic       s0, s1, busy, done;
  logic [3:0] sample;

  // Bench model of the 4:1 mux driven by the DUT selects.
  assign mux_out = ins[{s0, s1}];

  always #5 clk = ~clk;

  mux_scan_sampler #(.DWELL(DW), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .ch_mask (ch_mask),
    .mux_out (mux_out),
    .s0      (s0),
    .s1      (s1),
    .busy    (busy),
    .done    (done),
    .sample  (sample)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: plan holds the select for the current and every future
  // busy cycle; a channel is captured when its last dwell cycle ends.
  int         plan[$];
  int         m_sel = 0;
  logic [3:0] m_sample = 4'b0000;
  bit         m_done = 1'b0;

  always @(posedge clk) begin : model
    int c;
    if (rst) begin
      plan.delete();
      m_sel    = 0;
      m_sample = 4'b0000;
      m_done   = 1'b0;
    end else if (abort) begin
      plan.delete();
      m_done = 1'b0;
    end else if (plan.size() > 0) begin
      c = plan.pop_front();
      if (plan.size() == 0 || plan[0] != c) m_sample[c] = ins[c];
      if (plan.size() > 0) m_sel = plan[0];
      else                 m_done = 1'b1;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      m_sample = 4'b0000;
      if (ch_mask == 4'b0000) begin
        m_done = 1'b1;
      end else begin
        for (int ch = 0; ch < 4; ch++)
          if (ch_mask[ch]) repeat (DW) plan.push_back(ch);
        m_sel = plan[0];
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",   32'(busy),       32'(plan.size() != 0));
      check("done",   32'(done),       32'(m_done));
      check("sel",    32'({s0, s1}),   32'(m_sel[1:0]));
      check("sample", 32'(sample),     32'(m_sample));
    end
  end

  logic [1:0] seq_q[$];
  logic [1:0] exp1[8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
  logic [1:0] exp2[4] = '{2'd0, 2'd0, 2'd2, 2'd2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start from IDLE and measure done latency (edges after
  // the accepting edge), busy cycles and the select sequence.
  task automatic run_scan(input logic [3:0] m, output int lat, output int bc);
    start   = 1'b1;
    ch_mask = m;
    tick();
    start = 1'b0;
    lat = -1;
    bc  = 0;
    seq_q.delete();
    for (int n = 0; n <= 64; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (busy) begin
        bc++;
        seq_q.push_back({s0, s1});
      end
      tick();
    end
    tick();
  endtask

  initial begin
    int lat, bc, dcnt;

    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_done",   32'(done),      32'd0);
    check("rst_sel",    32'({s0, s1}),  32'd0);
    check("rst_sample", 32'(sample),    32'd0);
    tick();

    // Full mask, alternating inputs.
    ins = 4'b1010;
    run_scan(4'b1111, lat, bc);
    check("t1_latency", 32'(lat), 32'd8);
    check("t1_busy_cycles", 32'(bc), 32'd8);
    check("t1_seq_len", 32'(seq_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < seq_q.size(); i++)
      check("t1_seq", 32'(seq_q[i]), 32'(exp1[i]));
    check("t1_sample", 32'(sample), 32'b1010);
    check("t1_model_sample", 32'(m_sample), 32'b1010);

    // Sparse mask: channels 0 and 2 only.
    ins = 4'b0110;
    run_scan(4'b0101, lat, bc);
    check("t2_latency", 32'(lat), 32'd4);
    check("t2_busy_cycles", 32'(bc), 32'd4);
    check("t2_seq_len", 32'(seq_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < seq_q.size(); i++)
      check("t2_seq", 32'(seq_q[i]), 32'(exp2[i]));
    check("t2_sample", 32'(sample), 32'b0100);

    // Empty mask: immediate done, sample cleared.
    run_scan(4'b0000, lat, bc);
    check("t3_latency", 32'(lat), 32'd0);
    check("t3_busy_cycles", 32'(bc), 32'd0);
    check("t3_sample", 32'(sample), 32'b0000);

    // Abort after channel 0 captured, while channel 1 is selected.
    ins     = 4'b1111;
    start   = 1'b1;
    ch_mask = 4'b1111;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_sample", 32'(sample), 32'b0001);
    check("t4_sel_held", 32'({s0, s1}), 32'd1);
    dcnt = 0;
    repeat (6) begin
      if (done) dcnt++;
      tick();
    end
    check("t4_no_done", 32'(dcnt), 32'd0);
    run_scan(4'b1111, lat, bc);
    check("t4_rescan_latency", 32'(lat), 32'd8);
    check("t4_rescan_sample", 32'(sample), 32'b1111);

    // Start and mask change mid-scan are ignored.
    ins     = 4'b0101;
    start   = 1'b1;
    ch_mask = 4'b1111;
    tick();
    start = 1'b0;
    tick();
    start   = 1'b1;
    ch_mask = 4'b0001;
    tick();
    start = 1'b0;
    lat = -1;
    for (int n = 2; n <= 64; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      tick();
    end
    check("t5_latency", 32'(lat), 32'd8);
    check("t5_sample", 32'(sample), 32'b0101);
    dcnt = 0;
    repeat (5) begin
      tick();
      if (done) dcnt++;
    end
    check("t5_single_done", 32'(dcnt), 32'd0);

    // Reset mid-scan.
    ins     = 4'b1111;
    start   = 1'b1;
    ch_mask = 4'b1111;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_sel", 32'({s0, s1}), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_sample", 32'(sample), 32'd0);
    dcnt = 0;
    repeat (20) begin
      if (done) dcnt++;
      tick();
    end
    check("t6_no_done", 32'(dcnt), 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      ins     = 4'($urandom);
      ch_mask = 4'($urandom);
      start   = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    repeat (30) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
